// File: rtl/cordic_sched.sv
// -----------------------------------------------------------------------------
// cordic_sched
//
// Round-robin scheduler sharing one CORDIC engine between NUM_REQ requesters of
// the FOC datapath (current magnitude, flux angle, voltage limit, ...).
//
// Flow: IDLE picks the next requester, starting the search at the round-robin
// pointer. It latches that requester's operands toward the engine, issues a
// one-cycle grant together with the engine start pulse and moves to RUN.
// RUN waits for the engine done pulse, captures the results and raises a
// one-hot done toward the owner. RESP advances the pointer past the owner and
// returns to IDLE. Data passes through bit-exact. No arithmetic is done here.
//
// Optional feature (macro CORDIC_SCHED_TIMEOUT_EN):
//   An engine-done watchdog of TIMEOUT_CYC cycles. On expiry the owner gets
//   its done pulse with err_o=1 and zero results. Without the macro, RUN waits
//   indefinitely and err_o is tied low.
//
// Ports:
//   sys_clk_i    system clock, rising edge
//   reset_i      synchronous active-low reset (0 = reset)
//   req_i        level request, one bit per requester
//   req_x_i      packed x operands, requester k at [k*IO_WIDTH +: IO_WIDTH]
//   req_y_i      packed y operands, same packing
//   gnt_o        one-hot grant pulse (coincides with cor_start_o)
//   done_o       one-hot completion pulse
//   res_x_o      signed x result, shared by all requesters
//   res_y_o      signed y result, shared by all requesters
//   res_id_o     index of the requester owning the current job/result
//   err_o        high with done_o when the result is invalid (timeout)
//   busy_o       high while a job is owned (RUN or RESP)
//   cor_start_o  one-cycle start pulse to the engine
//   cor_x_o      x operand to the engine, held until the next grant
//   cor_y_o      y operand to the engine, held until the next grant
//   cor_done_i   engine completion pulse
//   cor_x_i      engine x result
//   cor_y_i      engine y result
// -----------------------------------------------------------------------------
module cordic_sched #(
  parameter int IO_WIDTH    = 18,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                         sys_clk_i,
  input  logic                         reset_i,
  input  logic [NUM_REQ-1:0]           req_i,
  input  logic [NUM_REQ*IO_WIDTH-1:0]  req_x_i,
  input  logic [NUM_REQ*IO_WIDTH-1:0]  req_y_i,
  output logic [NUM_REQ-1:0]           gnt_o,
  output logic [NUM_REQ-1:0]           done_o,
  output logic signed [IO_WIDTH-1:0]   res_x_o,
  output logic signed [IO_WIDTH-1:0]   res_y_o,
  output logic [ID_WIDTH-1:0]          res_id_o,
  output logic                         err_o,
  output logic                         busy_o,
  output logic                         cor_start_o,
  output logic [IO_WIDTH-1:0]          cor_x_o,
  output logic [IO_WIDTH-1:0]          cor_y_o,
  input  logic                         cor_done_i,
  input  logic [IO_WIDTH-1:0]          cor_x_i,
  input  logic [IO_WIDTH-1:0]          cor_y_i
);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter sanity
  // ---------------------------------------------------------------------------
  if (NUM_REQ < 2 || NUM_REQ > 8 || ID_WIDTH != $clog2(NUM_REQ) ||
      TIMEOUT_CYC < 1) begin : g_bad_params
    $error("cordic_sched: inconsistent NUM_REQ/ID_WIDTH/TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [ID_WIDTH:0]   NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);
  localparam logic [ID_WIDTH-1:0] LAST_ID   = ID_WIDTH'(NUM_REQ - 1);

  state_t              state;
  logic [ID_WIDTH-1:0] rr_ptr;

  // ---------------------------------------------------------------------------
  // Unpack operand buses so the winner can be selected by index
  // ---------------------------------------------------------------------------
  logic [IO_WIDTH-1:0] op_x [NUM_REQ];
  logic [IO_WIDTH-1:0] op_y [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign op_x[k] = req_x_i[k*IO_WIDTH +: IO_WIDTH];
    assign op_y[k] = req_y_i[k*IO_WIDTH +: IO_WIDTH];
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first set request at rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  // The candidate index is formed with one spare bit and folded back once,
  // which also covers NUM_REQ values that are not a power of two.
  // ---------------------------------------------------------------------------
  logic                pick_valid;
  logic [ID_WIDTH-1:0] pick_idx;
  logic [ID_WIDTH:0]   cand_sum;

  always_comb begin
    // NOTE: every variable gets a default before any conditional assignment,
    // otherwise paths that skip an assignment would infer a latch.
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand_sum   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
      if (cand_sum >= NUM_REQ_W) begin
        cand_sum = cand_sum - NUM_REQ_W;
      end
      if (!pick_valid && req_i[cand_sum[ID_WIDTH-1:0]]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_sum[ID_WIDTH-1:0];
      end
    end
  end

  logic [NUM_REQ-1:0] pick_onehot;
  logic [NUM_REQ-1:0] owner_onehot;

  assign pick_onehot  = NUM_REQ'(1) << pick_idx;
  // res_id_o is loaded with the winner at grant time, so it names the owner
  // of the job for the whole RUN/RESP span.
  assign owner_onehot = NUM_REQ'(1) << res_id_o;

`ifdef CORDIC_SCHED_TIMEOUT_EN
  // ---------------------------------------------------------------------------
  // Watchdog: counts cycles spent in RUN. Expiry is declared on the RUN cycle
  // in which the count would reach TIMEOUT_CYC; an engine done in that very
  // cycle still takes precedence.
  // ---------------------------------------------------------------------------
  localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Scheduler FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    if (!reset_i) begin
      // NOTE: the datapath registers are reset too, because all outputs must
      // read 0 during reset and an abandoned job must leave no stale result.
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      gnt_o       <= '0;
      done_o      <= '0;
      res_x_o     <= '0;
      res_y_o     <= '0;
      res_id_o    <= '0;
      busy_o      <= 1'b0;
      cor_start_o <= 1'b0;
      cor_x_o     <= '0;
      cor_y_o     <= '0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
      tmo_cnt     <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      gnt_o       <= '0;
      done_o      <= '0;
      cor_start_o <= 1'b0;
`ifdef CORDIC_SCHED_TIMEOUT_EN
      err_q       <= 1'b0;
`endif

      unique case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_o       <= pick_onehot;
            cor_start_o <= 1'b1;
            cor_x_o     <= op_x[pick_idx];
            cor_y_o     <= op_y[pick_idx];
            res_id_o    <= pick_idx;
            busy_o      <= 1'b1;
            state       <= ST_RUN;
`ifdef CORDIC_SCHED_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
          end
        end

        // Requests are ignored here; only the engine (or the watchdog) can
        // end the job.
        ST_RUN: begin
          if (cor_done_i) begin
            res_x_o <= cor_x_i;
            res_y_o <= cor_y_i;
            done_o  <= owner_onehot;
            state   <= ST_RESP;
          end
`ifdef CORDIC_SCHED_TIMEOUT_EN
          else if (tmo_cnt == TMO_LAST) begin
            res_x_o <= '0;
            res_y_o <= '0;
            done_o  <= owner_onehot;
            err_q   <= 1'b1;
            state   <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
`endif
        end

        // done_o is visible during this cycle; the owner moves to the back
        // of the round-robin order.
        ST_RESP: begin
          rr_ptr <= (res_id_o == LAST_ID) ? '0 : res_id_o + ID_WIDTH'(1);
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end

        default: begin
          busy_o <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// -----------------------------------------------------------------------------
// tb_cordic_sched
//
// Self-checking bench for cordic_sched (default parameters). A behavioural
// model predicts every registered output each cycle from the observed inputs;
// a compare process checks the DUT against it on every falling edge. Directed
// sequences pin the model with hand-computed literals (reset, round-robin
// order, single job, back-to-back, mid-job reset) before a randomized phase.
// A small engine model answers cor_start_o after a chosen or random latency
// and occasionally emits stray done pulses.
// -----------------------------------------------------------------------------
module tb_cordic_sched;

  localparam int W  = 18;
  localparam int N  = 4;
  localparam int IW = 2;

  logic             sys_clk_i;
  logic             reset_i;
  logic [N-1:0]     req_i;
  logic [N*W-1:0]   req_x_i;
  logic [N*W-1:0]   req_y_i;
  logic [N-1:0]     gnt_o;
  logic [N-1:0]     done_o;
  logic [W-1:0]     res_x_o;
  logic [W-1:0]     res_y_o;
  logic [IW-1:0]    res_id_o;
  logic             err_o;
  logic             busy_o;
  logic             cor_start_o;
  logic [W-1:0]     cor_x_o;
  logic [W-1:0]     cor_y_o;
  logic             cor_done_i = 1'b0;
  logic [W-1:0]     cor_x_i    = '0;
  logic [W-1:0]     cor_y_i    = '0;

  cordic_sched #(
    .IO_WIDTH   (W),
    .NUM_REQ    (N),
    .ID_WIDTH   (IW),
    .TIMEOUT_CYC(64)
  ) dut (
    .sys_clk_i  (sys_clk_i),
    .reset_i    (reset_i),
    .req_i      (req_i),
    .req_x_i    (req_x_i),
    .req_y_i    (req_y_i),
    .gnt_o      (gnt_o),
    .done_o     (done_o),
    .res_x_o    (res_x_o),
    .res_y_o    (res_y_o),
    .res_id_o   (res_id_o),
    .err_o      (err_o),
    .busy_o     (busy_o),
    .cor_start_o(cor_start_o),
    .cor_x_o    (cor_x_o),
    .cor_y_o    (cor_y_o),
    .cor_done_i (cor_done_i),
    .cor_x_i    (cor_x_i),
    .cor_y_i    (cor_y_i)
  );

  initial sys_clk_i = 1'b0;
  always #5 sys_clk_i = ~sys_clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired without the awaited event at %0t",
             name, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Engine model. eng_lat > 0 gives a fixed latency, 0 a random one (1..6).
  // ---------------------------------------------------------------------------
  int          eng_cnt   = 0;
  int          eng_lat   = 3;
  bit          eng_fix   = 1'b0;
  bit          eng_stray = 1'b0;
  logic [W-1:0] fix_x    = '0;
  logic [W-1:0] fix_y    = '0;

  always @(negedge sys_clk_i) begin
    bit fire;
    fire = 1'b0;
    cor_done_i = 1'b0;
    if (eng_cnt != 0) begin
      eng_cnt--;
      if (eng_cnt == 0) fire = 1'b1;
    end else if (eng_stray && $urandom_range(0, 29) == 0) begin
      fire = 1'b1;
    end
    if (fire) begin
      cor_done_i = 1'b1;
      cor_x_i    = eng_fix ? fix_x : W'($urandom);
      cor_y_i    = eng_fix ? fix_y : W'($urandom);
    end
    if (cor_start_o) eng_cnt = (eng_lat > 0) ? eng_lat : int'($urandom_range(1, 6));
  end

  // ---------------------------------------------------------------------------
  // Behavioural model: job owner, pointer and expected outputs, updated from
  // the inputs seen at each rising edge.
  // ---------------------------------------------------------------------------
  bit           m_valid = 1'b0;
  int           m_phase = 0;    // 0 free, 1 waiting for engine, 2 reporting
  int           m_ptr   = 0;
  int           m_owner = 0;
  logic [N-1:0] e_gnt   = '0;
  logic [N-1:0] e_done  = '0;
  logic         e_start = 1'b0;
  logic         e_busy  = 1'b0;
  logic [W-1:0] e_cx = '0, e_cy = '0, e_rx = '0, e_ry = '0;
  logic [IW-1:0] e_id = '0;

  // Winner = set requester with the smallest forward distance from the pointer.
  function automatic int rr_pick(input logic [N-1:0] r, input int ptr);
    int best;
    int best_d;
    best   = -1;
    best_d = N;
    for (int k = 0; k < N; k++) begin
      int d;
      d = (k - ptr + N) % N;
      if (r[k] && d < best_d) begin
        best   = k;
        best_d = d;
      end
    end
    return best;
  endfunction

  always @(posedge sys_clk_i) begin
    m_valid = 1'b1;
    e_gnt   = '0;
    e_done  = '0;
    e_start = 1'b0;
    if (!reset_i) begin
      m_phase = 0;
      m_ptr   = 0;
      e_busy  = 1'b0;
      e_cx = '0; e_cy = '0; e_rx = '0; e_ry = '0; e_id = '0;
    end else if (m_phase == 0) begin
      if (req_i != '0) begin
        m_owner = rr_pick(req_i, m_ptr);
        e_gnt   = N'(1) << m_owner;
        e_start = 1'b1;
        e_cx    = req_x_i[m_owner*W +: W];
        e_cy    = req_y_i[m_owner*W +: W];
        e_id    = IW'(m_owner);
        e_busy  = 1'b1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (cor_done_i) begin
        e_rx    = cor_x_i;
        e_ry    = cor_y_i;
        e_done  = N'(1) << m_owner;
        m_phase = 2;
      end
    end else begin
      m_ptr   = (m_owner + 1) % N;
      e_busy  = 1'b0;
      m_phase = 0;
    end
  end

  always @(negedge sys_clk_i) begin
    if (m_valid) begin
      check("gnt_o",       64'(gnt_o),       64'(e_gnt));
      check("cor_start_o", 64'(cor_start_o), 64'(e_start));
      check("done_o",      64'(done_o),      64'(e_done));
      check("busy_o",      64'(busy_o),      64'(e_busy));
      check("err_o",       64'(err_o),       64'(0));
      check("cor_x_o",     64'(cor_x_o),     64'(e_cx));
      check("cor_y_o",     64'(cor_y_o),     64'(e_cy));
      check("res_x_o",     64'(res_x_o),     64'(e_rx));
      check("res_y_o",     64'(res_y_o),     64'(e_ry));
      check("res_id_o",    64'(res_id_o),    64'(e_id));
    end
  end

  // ---------------------------------------------------------------------------
  // Bounded wait helpers (return the observed value and cycles waited)
  // ---------------------------------------------------------------------------
  task automatic wait_gnt(output logic [N-1:0] g, output int n);
    n = 0;
    do begin
      @(negedge sys_clk_i);
      n++;
    end while (gnt_o == '0 && n < 40);
    g = gnt_o;
    if (gnt_o == '0) bound_fail("wait_gnt");
  endtask

  task automatic wait_done(output logic [N-1:0] d, output int n);
    n = 0;
    do begin
      @(negedge sys_clk_i);
      n++;
    end while (done_o == '0 && n < 60);
    d = done_o;
    if (done_o == '0) bound_fail("wait_done");
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge sys_clk_i);
      n++;
    end while (busy_o && n < 80);
    if (busy_o) bound_fail("wait_idle");
  endtask

  task automatic set_ops(input int k, input logic [W-1:0] x,
                         input logic [W-1:0] y);
    req_x_i[k*W +: W] = x;
    req_y_i[k*W +: W] = y;
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [N-1:0] g, d, prev;
    int           n;

    reset_i = 1'b0;
    req_i   = 4'b1111;
    req_x_i = '0;
    req_y_i = '0;
    for (int k = 0; k < N; k++) set_ops(k, W'($urandom), W'($urandom));

    // Reset held with all requests pending: everything stays low.
    repeat (3) @(negedge sys_clk_i);
    check("rst_gnt",   64'(gnt_o),       64'(0));
    check("rst_start", 64'(cor_start_o), 64'(0));
    check("rst_done",  64'(done_o),      64'(0));
    check("rst_busy",  64'(busy_o),      64'(0));
    check("rst_res_x", 64'(res_x_o),     64'(0));

    // First edge after release grants requester 0.
    reset_i = 1'b1;
    @(negedge sys_clk_i);
    check("first_gnt",   64'(gnt_o),       64'(4'b0001));
    check("first_start", 64'(cor_start_o), 64'(1));
    check("first_busy",  64'(busy_o),      64'(1));

    // Round robin with all requests held: 0001 0010 0100 1000 0001.
    prev = gnt_o;
    for (int i = 1; i <= 4; i++) begin
      wait_done(d, n);
      check("rr_done", 64'(d), 64'(prev));
      wait_gnt(g, n);
      check("rr_gnt", 64'(g), 64'(4'b0001 << (i % 4)));
      prev = g;
    end
    req_i = '0;
    wait_done(d, n);
    check("rr_done_last", 64'(d), 64'(4'b0001));
    wait_idle();

    // Single requester with fixed engine answer after 20 cycles.
    set_ops(2, 18'h01000, 18'h00800);
    eng_lat = 20;
    eng_fix = 1'b1;
    fix_x   = 18'h011E3;
    fix_y   = 18'h00000;
    req_i   = 4'b0100;
    wait_gnt(g, n);
    req_i = '0;
    check("single_gnt", 64'(g),       64'(4'b0100));
    check("single_cx",  64'(cor_x_o), 64'(18'h01000));
    check("single_cy",  64'(cor_y_o), 64'(18'h00800));
    wait_done(d, n);
    check("single_done", 64'(d),        64'(4'b0100));
    check("single_lat",  64'(n),        64'(21));
    check("single_rx",   64'(res_x_o),  64'(18'h011E3));
    check("single_ry",   64'(res_y_o),  64'(0));
    check("single_id",   64'(res_id_o), 64'(2));
    check("single_err",  64'(err_o),    64'(0));
    eng_fix = 1'b0;
    eng_lat = 3;
    wait_idle();

    // Back-to-back: requester 3 keeps its request after the grant.
    req_i = 4'b1000;
    wait_gnt(g, n);
    check("b2b_gnt3", 64'(g), 64'(4'b1000));
    req_i = 4'b1001;
    wait_done(d, n);
    check("b2b_done3", 64'(d), 64'(4'b1000));
    wait_gnt(g, n);
    check("b2b_other", 64'(g), 64'(4'b0001));
    req_i = 4'b1000;
    wait_done(d, n);
    check("b2b_done0", 64'(d), 64'(4'b0001));
    wait_gnt(g, n);
    check("b2b_regnt", 64'(g), 64'(4'b1000));
    check("b2b_gap",   64'(n), 64'(2));
    req_i = '0;
    wait_done(d, n);
    wait_idle();

    // Move the pointer off 0, then abandon a job with a one-cycle reset.
    req_i = 4'b0001;
    wait_gnt(g, n);
    req_i = '0;
    wait_done(d, n);
    wait_idle();
    eng_lat = 10;
    req_i = 4'b0100;
    wait_gnt(g, n);
    req_i = '0;
    check("mid_gnt", 64'(g), 64'(4'b0100));
    repeat (3) @(negedge sys_clk_i);
    reset_i = 1'b0;
    @(negedge sys_clk_i);
    reset_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge sys_clk_i);
      check("mid_rst_nodone", 64'(done_o), 64'(0));
      check("mid_rst_idle",   64'(busy_o), 64'(0));
    end
    req_i = 4'b1111;
    wait_gnt(g, n);
    req_i = '0;
    check("mid_rst_ptr", 64'(g), 64'(4'b0001));
    wait_done(d, n);
    wait_idle();

    // Randomized traffic with random engine latency and stray done pulses.
    eng_lat   = 0;
    eng_stray = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      @(negedge sys_clk_i);
      for (int k = 0; k < N; k++) begin
        if (gnt_o[k]) begin
          if ($urandom_range(0, 3) != 0) req_i[k] = 1'b0;
        end else if (!req_i[k] && $urandom_range(0, 2) == 0) begin
          set_ops(k, W'($urandom), W'($urandom));
          req_i[k] = 1'b1;
        end
      end
    end
    req_i     = '0;
    eng_stray = 1'b0;
    wait_idle();
    repeat (4) @(negedge sys_clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "tb_cordic_sched watchdog");
  end

endmodule
